// File: rtl/fetch_queue_if.sv
// Instruction fetch front end: sequential fetch requests, an in-order
// response queue, stall back-pressure and flush/redirect handling.
module fetch_queue_if #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic [31:0] REDIRECT_PC,
  input  logic        STALL,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] Instr1_IF,
  output logic [31:0] Instr_PC_IF,
  output logic [31:0] Instr_PC_Plus4_IF,
  output logic        Instr_VALID_IF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW+1:0] inuse;
  logic          issue;
  logic          take;
  logic          push;
  logic          pop;
  logic          valid;
  logic [31:0]   redir_pc;
  logic          unused_redir;

  assign unused_redir = ^REDIRECT_PC[1:0];
  assign redir_pc     = {REDIRECT_PC[31:2], 2'b00};

  assign inuse = {2'b00, count_q} + {2'b00, outst_q}
               + {2'b00, drop_q};

  // RESET gating keeps the request low while reset is held
  assign issue = RESET && !FLUSH
              && (inuse < (CW+2)'(DEPTH));

  // a response with nothing left to drop belongs to a live request
  assign take = IMEM_RVALID && (drop_q == '0);
  assign push = take && !FLUSH;
  assign pop  = (count_q != '0) && !STALL && !FLUSH;

  assign valid = (count_q != '0);

  assign IMEM_REQ  = issue;
  assign IMEM_ADDR = fetch_pc_q;

  assign Instr_VALID_IF    = valid;
  assign Instr1_IF         = valid ? instr_q[head_q] : '0;
  assign Instr_PC_IF       = valid ? pc_q[head_q] : '0;
  assign Instr_PC_Plus4_IF = valid ? pc_q[head_q] + 32'd4 : '0;

  // next-state: flush overrides issue, push and pop
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (FLUSH) begin
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      outst_d    = '0;
      drop_d     = drop_q + outst_q
                 - CW'(IMEM_RVALID);
    end else begin
      if (issue)
        fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + AW'(1);
      end
      if (pop)
        head_d = head_q + AW'(1);
      outst_d = outst_q + CW'(issue) - CW'(take);
      drop_d  = drop_q
              - CW'(IMEM_RVALID && !take);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // pointer, counter and pc registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // queue storage, written at the tail on each accepted response
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[tail_q] <= IMEM_RDATA;
      pc_q[tail_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue_if.sv
// Bench for fetch_queue_if: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_fetch_queue_if;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'hBFC00000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        STALL = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic [31:0] Instr1_IF;
  logic [31:0] Instr_PC_IF;
  logic [31:0] Instr_PC_Plus4_IF;
  logic        Instr_VALID_IF;

  fetch_queue_if #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .REDIRECT_PC(REDIRECT_PC), .STALL(STALL),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .Instr1_IF(Instr1_IF), .Instr_PC_IF(Instr_PC_IF),
    .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF),
    .Instr_VALID_IF(Instr_VALID_IF)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  typedef struct {
    logic        flush;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  mreq_t       memq[$];
  int          lat = 1;
  int          cyc = 0;

  logic [31:0] m_fpc;
  int          m_drop;
  logic [31:0] m_infl[$];
  logic [31:0] m_q[$];

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr, s_p4;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'h5EED1234) * 32'h9E3779B1 + 32'h1357;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fpc  = RPC;
    m_drop = 0;
    m_infl.delete();
    m_q.delete();
    memq.delete();
  endtask

  // one clock: drive at negedge, check, then advance model at posedge
  task automatic cycle(input logic fl, input logic [31:0] rpc,
                       input logic st);
    logic        rv, ereq;
    logic [31:0] rd, p;
    mreq_t       t;
    @(negedge CLK);
    rv = 1'b0;
    rd = '0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      t  = memq.pop_front();
      rv = 1'b1;
      rd = memf(t.a);
    end
    IMEM_RVALID = rv;
    IMEM_RDATA  = rd;
    FLUSH       = fl;
    REDIRECT_PC = rpc;
    STALL       = st;
    #1;
    s_req   = IMEM_REQ;
    s_addr  = IMEM_ADDR;
    s_valid = Instr_VALID_IF;
    s_pc    = Instr_PC_IF;
    s_instr = Instr1_IF;
    s_p4    = Instr_PC_Plus4_IF;
    ereq = !fl && (m_q.size() + m_infl.size() + m_drop) < DEPTH;
    chk("req", s_req, ereq);
    chk("addr", s_addr, m_fpc);
    if (m_q.size() > 0) begin
      chk("valid", s_valid, 1);
      chk("pc", s_pc, m_q[0]);
      chk("instr", s_instr, memf(m_q[0]));
      chk("plus4", s_p4, m_q[0] + 32'd4);
    end else begin
      chk("valid", s_valid, 0);
      chk("pc", s_pc, 0);
      chk("instr", s_instr, 0);
      chk("plus4", s_p4, 0);
    end
    @(posedge CLK);
    if (s_req) memq.push_back('{s_addr, cyc + lat});
    if (!fl && !st && m_q.size() > 0) p = m_q.pop_front();
    if (rv) begin
      if (m_drop > 0) m_drop--;
      else if (m_infl.size() > 0) begin
        p = m_infl.pop_front();
        if (!fl) m_q.push_back(p);
      end
    end
    if (fl) begin
      m_q.delete();
      m_drop += m_infl.size();
      m_infl.delete();
      m_fpc = {rpc[31:2], 2'b00};
    end else if (ereq) begin
      m_infl.push_back(m_fpc);
      m_fpc += 32'd4;
    end
    cyc++;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_req"}, IMEM_REQ, 0);
    chk({nm, "_addr"}, IMEM_ADDR, RPC);
    chk({nm, "_valid"}, Instr_VALID_IF, 0);
    chk({nm, "_instr"}, Instr1_IF, 0);
    chk({nm, "_pc"}, Instr_PC_IF, 0);
    chk({nm, "_p4"}, Instr_PC_Plus4_IF, 0);
  endtask

  // assert reset mid-cycle, check outputs at once, release after edge
  task automatic do_reset(input string nm);
    @(negedge CLK);
    #2;
    RESET       = 1'b0;
    IMEM_RVALID = 1'b0;
    FLUSH       = 1'b0;
    STALL       = 1'b0;
    #1;
    chk_reset_outs(nm);
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
  endtask

  vec_t tv[6];

  initial begin
    int          nreq, k;
    logic        seen;
    logic [31:0] addrs[3];

    tv[0] = '{0, 0, 1, RPC,         0, 32'h0};
    tv[1] = '{0, 0, 1, RPC + 32'h4, 0, 32'h0};
    tv[2] = '{0, 0, 1, RPC + 32'h8, 1, RPC};
    tv[3] = '{0, 0, 1, RPC + 32'hC, 1, RPC + 32'h4};
    tv[4] = '{0, 0, 1, RPC + 32'h10, 1, RPC + 32'h8};
    tv[5] = '{0, 0, 1, RPC + 32'h14, 1, RPC + 32'hC};

    model_reset();
    @(posedge CLK);
    #2;
    chk_reset_outs("rst0");
    @(posedge CLK);
    #2;
    RESET = 1'b1;

    // reset release, latency 1, free-running
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(tv[i].flush, 32'h0, tv[i].stall);
      chk("t1_req", s_req, tv[i].req);
      chk("t1_addr", s_addr, tv[i].addr);
      chk("t1_valid", s_valid, tv[i].valid);
      chk("t1_pc", s_pc, tv[i].pc);
      chk("t1_p4", s_p4, tv[i].valid ? tv[i].pc + 32'd4 : 32'h0);
    end

    // stall fills queue+in-flight to DEPTH, then drains in order
    cycle(1, 32'h00010000, 0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 32'h0, 1);
      if (s_req) nreq++;
    end
    chk("t2_nreq", nreq, 4);
    chk("t2_hold_pc", s_pc, 32'h00010000);
    chk("t2_hold_valid", s_valid, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 32'h0, 0);
      chk("t2_drain_valid", s_valid, 1);
      chk("t2_drain_pc", s_pc, 32'h00010000 + 32'(4 * i));
    end

    // flush with three requests outstanding at latency 3
    lat = 3;
    cycle(1, 32'h00000100, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0);
    cycle(1, 32'h00400103, 0);
    cycle(0, 32'h0, 0);
    chk("t3_req", s_req, 1);
    chk("t3_addr", s_addr, 32'h00400100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(0, 32'h0, 0);
      if (s_valid) begin
        seen = 1'b1;
        chk("t3_first_pc", s_pc, 32'h00400100);
      end
    end
    if (!seen) chk("t3_timeout", 0, 1);

    // back-to-back flush, responses arriving in both cycles
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0);
    cycle(1, 32'h00001000, 0);
    cycle(1, 32'h00002000, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 32'h0, 0);
      if (s_valid) begin
        if (!seen) chk("t4_first_pc", s_pc, 32'h00002000);
        seen = 1'b1;
        chk("t4_range", (s_pc >= 32'h2000 && s_pc < 32'h2100), 1);
      end
    end
    if (!seen) chk("t4_timeout", 0, 1);

    // address wrap at the top of the address space
    lat = 1;
    cycle(1, 32'hFFFFFFF8, 0);
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle(0, 32'h0, 0);
      if (s_req && k < 3) begin
        addrs[k] = s_addr;
        k++;
      end
      if (s_valid && s_pc == 32'hFFFFFFFC) begin
        seen = 1'b1;
        chk("t5_p4_wrap", s_p4, 32'h0);
      end
    end
    if (!seen) chk("t5_timeout", 0, 1);
    chk("t5_nreq", k, 3);
    if (k == 3) begin
      chk("t5_a0", addrs[0], 32'hFFFFFFF8);
      chk("t5_a1", addrs[1], 32'hFFFFFFFC);
      chk("t5_a2", addrs[2], 32'h00000000);
    end

    // reset while queue holds words and requests are in flight
    lat = 3;
    cycle(1, 32'h00003000, 0);
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 1);
    chk("t6_prefill_valid", s_valid, 1);
    do_reset("t6");
    cycle(0, 32'h0, 0);
    chk("t6_req", s_req, 1);
    chk("t6_addr", s_addr, RPC);

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic        fl, st;
      logic [31:0] rpc;
      if (i % 200 == 0) lat = $urandom_range(1, 4);
      fl  = ($urandom % 20) == 0;
      st  = ($urandom % 3) == 0;
      rpc = ($urandom % 4 == 0) ? (32'hFFFFFFE0 | ($urandom & 32'h1F))
                                : $urandom;
      if ($urandom % 600 == 0) do_reset("rnd_rst");
      else cycle(fl, rpc, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
